apx_float_error_monitor: RTL and testbench

Downstream checker for the approximate float32 adder. It consumes the accurate adder result and the approximate adder result through their stb/ack output handshakes, pairs them, and computes the ULP distance between them. It keeps running error statistics (samples, bitwise mismatches, out-of-tolerance count, maximum ULP error) and presents a per-sample result through its own stb/ack handshake. It replaces the per-pair `!==` check at the bench level and is synthesizable for on-FPGA error characterisation.

---
 rtl/apx_float_error_monitor.sv | 262 ++++++++++++++++++++++++++
 tb/tb_apx_float_error_monitor.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apx_float_error_monitor.sv
// ---------------------------------------------------------------------------
// apx_float_error_monitor
//
// Pairs the accurate and approximate float32 adder results, measures their
// distance in units in the last place (ULP) and keeps running statistics for
// error characterisation. Each pair goes through four states:
//   WAIT   - capture each input word on its own stb/ack handshake
//   DIFF   - compute the ULP distance and the bitwise mismatch flag
//   UPDATE - register the per-sample result and update the statistics
//   REPORT - present the result on result_stb until result_ack is sampled
//
// Optional feature (compile-time macro APX_ERR_SUM_EN): adds a 48-bit
// saturating accumulator ulp_sum of all ULP errors, with its own port.
//
// Parameters
//   CNT_W    width of the saturating statistics counters
//   ULP_TOL  a sample is out of tolerance when its ULP error exceeds this
//
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   acc_z / acc_z_stb / acc_z_ack accurate result handshake (input channel)
//   apx_z / apx_z_stb / apx_z_ack approximate result handshake (input channel)
//   ulp_err, mismatch             result of the last completed pair
//   result_stb / result_ack       per-sample result handshake (output channel)
//   sample_cnt                    pairs completed
//   mismatch_cnt                  pairs that differ bitwise
//   tol_fail_cnt                  pairs with ulp_err > ULP_TOL
//   max_ulp_err                   largest ulp_err since reset
//   ulp_sum                       accumulated ULP error (APX_ERR_SUM_EN only)
// ---------------------------------------------------------------------------
module apx_float_error_monitor #(
    parameter int          CNT_W   = 16,
    parameter logic [31:0] ULP_TOL = 32'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      acc_z,
    input  logic             acc_z_stb,
    output logic             acc_z_ack,
    input  logic [31:0]      apx_z,
    input  logic             apx_z_stb,
    output logic             apx_z_ack,
    output logic [31:0]      ulp_err,
    output logic             mismatch,
    output logic             result_stb,
    input  logic             result_ack,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] tol_fail_cnt,
`ifdef APX_ERR_SUM_EN
    output logic [47:0]      ulp_sum,
`endif
    output logic [31:0]      max_ulp_err
);

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        DIFF   = 2'd1,
        UPDATE = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Goes high on the first clock edge after reset release; keeps both
    // acks low while the monitor is held in (or just leaving) reset.
    logic        ready;

    logic        acc_held;
    logic        apx_held;
    logic [31:0] acc_q;
    logic [31:0] apx_q;
    logic        acc_fire;
    logic        apx_fire;

    logic signed [32:0] key_acc;
    logic signed [32:0] key_apx;
    logic signed [33:0] key_delta;
    logic [31:0]        d_calc;
    logic               mm_calc;

    logic [31:0]        d_p1;
    logic               mm_p1;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------
    function automatic logic is_nan(input logic [31:0] z);
        return (z[30:23] == 8'hFF) && (z[22:0] != 23'd0);
    endfunction

    // Maps a float onto a signed integer line so that adjacent
    // representable values differ by exactly one; +0 and -0 both map to 0.
    function automatic logic signed [32:0] ulp_key(input logic [31:0] z);
        logic signed [32:0] mag;
        mag = {2'b00, z[30:0]};
        return z[31] ? -mag : mag;
    endfunction

    function automatic logic [31:0] abs_sat(input logic signed [33:0] v);
        logic [33:0] m;
        m = v[33] ? 34'(-v) : 34'(v);
        if (m[33:32] != 2'b00) begin
            return 32'hFFFF_FFFF;
        end
        return m[31:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

`ifdef APX_ERR_SUM_EN
    function automatic logic [47:0] sat_add48(input logic [47:0] s,
                                              input logic [31:0] d);
        logic [48:0] t;
        t = {1'b0, s} + {17'd0, d};
        return t[48] ? 48'hFFFF_FFFF_FFFF : t[47:0];
    endfunction
`endif

    // -----------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        acc_z_ack  = 1'b0;
        apx_z_ack  = 1'b0;
        result_stb = 1'b0;
        case (state)
            WAIT: begin
                acc_z_ack = ready && !acc_held;
                apx_z_ack = ready && !apx_held;
                if (acc_held && apx_held) begin
                    state_next = DIFF;
                end
            end
            DIFF: begin
                state_next = UPDATE;
            end
            UPDATE: begin
                state_next = REPORT;
            end
            REPORT: begin
                result_stb = 1'b1;
                if (result_ack) begin
                    state_next = WAIT;
                end
            end
            default: begin
                state_next = WAIT;
            end
        endcase
    end

    assign acc_fire = acc_z_stb && acc_z_ack;
    assign apx_fire = apx_z_stb && apx_z_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WAIT;
            ready <= 1'b0;
        end else begin
            state <= state_next;
            ready <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 0: independent capture of the two input words
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_held <= 1'b0;
            apx_held <= 1'b0;
            acc_q    <= 32'd0;
            apx_q    <= 32'd0;
        end else begin
            if (acc_fire) begin
                acc_q    <= acc_z;
                acc_held <= 1'b1;
            end
            if (apx_fire) begin
                apx_q    <= apx_z;
                apx_held <= 1'b1;
            end
            // Release both words as the FSM returns to WAIT so the acks
            // re-assert in the first WAIT cycle.
            if (state == REPORT && result_ack) begin
                acc_held <= 1'b0;
                apx_held <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: ULP distance (evaluated in DIFF)
    // -----------------------------------------------------------------------
    always_comb begin
        key_acc   = ulp_key(acc_q);
        key_apx   = ulp_key(apx_q);
        key_delta = {key_acc[32], key_acc} - {key_apx[32], key_apx};
        d_calc    = abs_sat(key_delta);
        // A NaN has no position on the number line: two NaNs count as
        // agreeing, a single NaN as the worst possible error.
        if (is_nan(acc_q) && is_nan(apx_q)) begin
            d_calc = 32'd0;
        end else if (is_nan(acc_q) != is_nan(apx_q)) begin
            d_calc = 32'hFFFF_FFFF;
        end
        mm_calc = (acc_q != apx_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_p1  <= 32'd0;
            mm_p1 <= 1'b0;
        end else if (state == DIFF) begin
            d_p1  <= d_calc;
            mm_p1 <= mm_calc;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: per-sample result and statistics (committed in UPDATE)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ulp_err      <= 32'd0;
            mismatch     <= 1'b0;
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
            tol_fail_cnt <= '0;
            max_ulp_err  <= 32'd0;
        end else if (state == UPDATE) begin
            ulp_err    <= d_p1;
            mismatch   <= mm_p1;
            sample_cnt <= sat_inc(sample_cnt);
            if (mm_p1) begin
                mismatch_cnt <= sat_inc(mismatch_cnt);
            end
            if (d_p1 > ULP_TOL) begin
                tol_fail_cnt <= sat_inc(tol_fail_cnt);
            end
            if (d_p1 > max_ulp_err) begin
                max_ulp_err <= d_p1;
            end
        end
    end

`ifdef APX_ERR_SUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ulp_sum <= 48'd0;
        end else if (state == UPDATE) begin
            ulp_sum <= sat_add48(ulp_sum, d_p1);
        end
    end
`endif

endmodule

// File: tb/tb_apx_float_error_monitor.sv
// ---------------------------------------------------------------------------
// tb_apx_float_error_monitor
//
// Bench for apx_float_error_monitor. Two instances share the same stimulus:
// the main one (CNT_W = 16, ULP_TOL = 0) and a narrow one (CNT_W = 4,
// ULP_TOL = 3) whose counters saturate quickly. Directed vectors come from a
// table, followed by reset and accumulator sequences and randomized pairs.
// Expected ULP distances come from a reference model that places each float
// on an integer number line with plain 64-bit arithmetic.
// Honours APX_ERR_SUM_EN (ulp_sum checked when defined).
// ---------------------------------------------------------------------------
module tb_apx_float_error_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] acc_z;
    logic        acc_z_stb;
    logic [31:0] apx_z;
    logic        apx_z_stb;
    logic        result_ack;

    logic        acc_z_ack, apx_z_ack, mismatch, result_stb;
    logic [31:0] ulp_err, max_ulp_err;
    logic [15:0] sample_cnt, mismatch_cnt, tol_fail_cnt;

    logic        s_acc_ack, s_apx_ack, s_mismatch, s_result_stb;
    logic [31:0] s_ulp_err, s_max_ulp_err;
    logic [3:0]  s_sample_cnt, s_mismatch_cnt, s_tol_fail_cnt;
`ifdef APX_ERR_SUM_EN
    logic [47:0] ulp_sum, s_ulp_sum;
`endif

    int checks = 0;
    int errors = 0;

    // Reference-model statistics since the last reset
    longint unsigned m_samples, m_mm, m_tol0, m_tol3, m_max, m_sum;

    always #5 clk = ~clk;

    apx_float_error_monitor #(.CNT_W(16), .ULP_TOL(32'd0)) dut (
        .clk(clk), .rst(rst),
        .acc_z(acc_z), .acc_z_stb(acc_z_stb), .acc_z_ack(acc_z_ack),
        .apx_z(apx_z), .apx_z_stb(apx_z_stb), .apx_z_ack(apx_z_ack),
        .ulp_err(ulp_err), .mismatch(mismatch),
        .result_stb(result_stb), .result_ack(result_ack),
        .sample_cnt(sample_cnt), .mismatch_cnt(mismatch_cnt),
        .tol_fail_cnt(tol_fail_cnt),
`ifdef APX_ERR_SUM_EN
        .ulp_sum(ulp_sum),
`endif
        .max_ulp_err(max_ulp_err)
    );

    apx_float_error_monitor #(.CNT_W(4), .ULP_TOL(32'd3)) dut_sat (
        .clk(clk), .rst(rst),
        .acc_z(acc_z), .acc_z_stb(acc_z_stb), .acc_z_ack(s_acc_ack),
        .apx_z(apx_z), .apx_z_stb(apx_z_stb), .apx_z_ack(s_apx_ack),
        .ulp_err(s_ulp_err), .mismatch(s_mismatch),
        .result_stb(s_result_stb), .result_ack(result_ack),
        .sample_cnt(s_sample_cnt), .mismatch_cnt(s_mismatch_cnt),
        .tol_fail_cnt(s_tol_fail_cnt),
`ifdef APX_ERR_SUM_EN
        .ulp_sum(s_ulp_sum),
`endif
        .max_ulp_err(s_max_ulp_err)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          lead;       // cycles apx_z_stb precedes acc_z_stb
        int          ack_delay;  // cycles result_ack is held low in REPORT
        logic [31:0] ulp;
        logic        mm;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint unsigned ref_ulp(input logic [31:0] a,
                                                input logic [31:0] b);
        bit     na, nb;
        longint ka, kb, d;
        na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (na && nb) return 0;
        if (na || nb) return 64'hFFFF_FFFF;
        ka = longint'({33'd0, a[30:0]});
        kb = longint'({33'd0, b[30:0]});
        if (a[31]) ka = -ka;
        if (b[31]) kb = -kb;
        d = ka - kb;
        if (d < 0) d = -d;
        if (d > 64'hFFFF_FFFF) d = 64'hFFFF_FFFF;
        return d;
    endfunction

    function automatic longint unsigned sat(input longint unsigned v, input int w);
        longint unsigned lim;
        lim = (64'd1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_samples = 0; m_mm = 0; m_tol0 = 0; m_tol3 = 0; m_max = 0; m_sum = 0;
    endtask

    task automatic model_update(input logic [31:0] a, input logic [31:0] b);
        longint unsigned d;
        d = ref_ulp(a, b);
        m_samples++;
        if (a != b) m_mm++;
        if (d > 0) m_tol0++;
        if (d > 3) m_tol3++;
        if (d > m_max) m_max = d;
        m_sum = sat(m_sum + d, 48);
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_sample_cnt"},   64'(sample_cnt),     sat(m_samples, 16));
        check({tag, "_mismatch_cnt"}, 64'(mismatch_cnt),   sat(m_mm, 16));
        check({tag, "_tol_fail_cnt"}, 64'(tol_fail_cnt),   sat(m_tol0, 16));
        check({tag, "_max_ulp"},      64'(max_ulp_err),    m_max);
        check({tag, "_s_sample_cnt"}, 64'(s_sample_cnt),   sat(m_samples, 4));
        check({tag, "_s_mismatch"},   64'(s_mismatch_cnt), sat(m_mm, 4));
        check({tag, "_s_tol_fail"},   64'(s_tol_fail_cnt), sat(m_tol3, 4));
        check({tag, "_s_max_ulp"},    64'(s_max_ulp_err),  m_max);
`ifdef APX_ERR_SUM_EN
        check({tag, "_ulp_sum"},      64'(ulp_sum),        m_sum);
        check({tag, "_s_ulp_sum"},    64'(s_ulp_sum),      m_sum);
`endif
    endtask

    // Drives one pair through both handshakes and checks the result.
    // Called with the bench sitting #1 after a rising edge in WAIT.
    task automatic run_pair(input logic [31:0] a, input logic [31:0] b,
                            input int lead, input int ack_delay,
                            input logic hold_ack, input logic [31:0] exp_ulp,
                            input logic exp_mm, input string tag);
        bit a_done = 0, b_done = 0, bad_ack = 0, bad_stb = 0, unstable = 0;
        bit fa, fb;
        int t = 0;
        int lat = 0;
        result_ack = hold_ack;
        acc_z = a;
        while (!(a_done && b_done) && t < 40) begin
            acc_z_stb = !a_done && (t >= lead);
            // In staggered mode apx_z_stb stays high with junk data after
            // its capture; the held word must not be overwritten.
            apx_z_stb = (lead > 0) ? 1'b1 : !b_done;
            apx_z     = b_done ? ~b : b;
            if ((a_done && acc_z_ack) || (b_done && apx_z_ack)) bad_ack = 1;
            if (result_stb) bad_stb = 1;
            fa = acc_z_stb && acc_z_ack;
            fb = apx_z_stb && apx_z_ack;
            @(posedge clk); #1;
            if (fa) a_done = 1;
            if (fb) b_done = 1;
            t++;
        end
        acc_z_stb = 1'b0;
        apx_z_stb = 1'b0;
        check({tag, "_capture"}, 64'(a_done && b_done), 64'd1);
        if (!(a_done && b_done)) return;
        check({tag, "_ack_drop"}, 64'(bad_ack), 64'd0);
        check({tag, "_early_stb"}, 64'(bad_stb), 64'd0);
        while (!result_stb && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd3);
        model_update(a, b);
        check({tag, "_ulp_err"},  64'(ulp_err),    64'(exp_ulp));
        check({tag, "_mismatch"}, 64'(mismatch),   64'(exp_mm));
        check({tag, "_s_ulp"},    64'(s_ulp_err),  64'(exp_ulp));
        check({tag, "_s_stb"},    64'(s_result_stb), 64'd1);
        check_stats(tag);
        for (int i = 0; i < ack_delay; i++) begin
            @(posedge clk); #1;
            if (!result_stb || ulp_err !== exp_ulp) unstable = 1;
        end
        if (ack_delay > 0) check({tag, "_hold"}, 64'(unstable), 64'd0);
        result_ack = 1'b1;
        @(posedge clk); #1;
        check({tag, "_stb_drop"}, 64'(result_stb), 64'd0);
        check({tag, "_rearm"}, 64'({acc_z_ack, apx_z_ack, s_acc_ack, s_apx_ack}),
              64'hF);
        result_ack = hold_ack;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        int          mode;

        vecs[0] = '{32'h3F800000, 32'h3F800001, 0, 0, 32'h00000001, 1'b1};
        vecs[1] = '{32'h00000000, 32'h80000000, 0, 0, 32'h00000000, 1'b1};
        vecs[2] = '{32'h00000001, 32'h80000001, 0, 0, 32'h00000002, 1'b1};
        vecs[3] = '{32'h7FC00000, 32'h3F800000, 0, 0, 32'hFFFFFFFF, 1'b1};
        vecs[4] = '{32'h7FC00000, 32'h7FC00000, 0, 0, 32'h00000000, 1'b0};
        vecs[5] = '{32'h40000000, 32'h3F800000, 4, 6, 32'h00800000, 1'b1};
        vecs[6] = '{32'hBF800000, 32'h3F800000, 0, 2, 32'h7F000000, 1'b1};
        vecs[7] = '{32'h12345678, 32'h12345678, 0, 0, 32'h00000000, 1'b0};
        vecs[8] = '{32'h7F800000, 32'h7F7FFFFF, 0, 1, 32'h00000001, 1'b1};
        vecs[9] = '{32'hFF800001, 32'h7FC00001, 0, 0, 32'h00000000, 1'b1};

        rst        = 1'b0;
        acc_z      = 32'd0;
        apx_z      = 32'd0;
        acc_z_stb  = 1'b0;
        apx_z_stb  = 1'b0;
        result_ack = 1'b0;
        model_reset();

        // Reset state
        #1;
        check("reset_outputs", 64'({ulp_err, mismatch, result_stb, acc_z_ack,
                                    apx_z_ack}), 64'd0);
        check_stats("reset");
        repeat (3) @(posedge clk);
        #1;
        check("reset_acks_held", 64'({acc_z_ack, apx_z_ack}), 64'd0);
        rst = 1'b1;
        #1;
        check("release_acks_low", 64'({acc_z_ack, apx_z_ack}), 64'd0);
        @(posedge clk); #1;
        check("release_acks_rise", 64'({acc_z_ack, apx_z_ack}), 64'h3);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_pair(vecs[i].a, vecs[i].b, vecs[i].lead, vecs[i].ack_delay,
                     1'b0, vecs[i].ulp, vecs[i].mm, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_model", i), ref_ulp(vecs[i].a, vecs[i].b),
                  64'(vecs[i].ulp));
        end

        // Reset in the middle of a pair: only the accurate word is held
        acc_z     = 32'h40400000;
        acc_z_stb = 1'b1;
        @(posedge clk); #1;
        acc_z_stb = 1'b0;
        check("midpair_acc_held", 64'({acc_z_ack, apx_z_ack}), 64'h1);
        rst = 1'b0;
        #1;
        model_reset();
        check("midpair_reset_acks", 64'({acc_z_ack, apx_z_ack}), 64'd0);
        check("midpair_reset_out", 64'({ulp_err, mismatch, result_stb}), 64'd0);
        check_stats("midpair_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midpair_release_low", 64'({acc_z_ack, apx_z_ack}), 64'd0);
        @(posedge clk); #1;
        check("midpair_release_rise", 64'({acc_z_ack, apx_z_ack}), 64'h3);

        // Three pairs of error 5; the partial pair above must not count
        run_pair(32'h3F800000, 32'h3F800005, 2, 0, 1'b0, 32'd5, 1'b1, "err5_a");
        check("after_reset_sample_cnt", 64'(sample_cnt), 64'd1);
        run_pair(32'h00000005, 32'h00000000, 0, 0, 1'b1, 32'd5, 1'b1, "err5_b");
        run_pair(32'h80000002, 32'h00000003, 0, 1, 1'b0, 32'd5, 1'b1, "err5_c");
`ifdef APX_ERR_SUM_EN
        check("ulp_sum_15", 64'(ulp_sum), 64'd15);
`endif
        check("err5_tol3_cnt", 64'(s_tol_fail_cnt), 64'd3);

        // Randomized mismatching pairs, back to back or with ack delays
        for (int i = 0; i < 40; i++) begin
            ra   = $urandom;
            mode = $urandom_range(0, 3);
            case (mode)
                0:       rb = ra + $urandom_range(1, 7);
                1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
                2:       rb = ra ^ 32'h80000000;
                default: rb = (ra == 32'h7FC00123) ? 32'h7FA00001 : 32'h7FC00123;
            endcase
            if ((i % 2) == 0) begin
                run_pair(ra, rb, 0, 0, 1'b1, 32'(ref_ulp(ra, rb)), 1'b1,
                         $sformatf("rnd%0d", i));
            end else begin
                run_pair(ra, rb, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0,
                         32'(ref_ulp(ra, rb)), 1'b1, $sformatf("rnd%0d", i));
            end
        end

        // Narrow instance: 43 mismatching pairs since reset, counters pinned
        check("sat_sample_cnt", 64'(s_sample_cnt), 64'd15);
        check("sat_mismatch_cnt", 64'(s_mismatch_cnt), 64'd15);
        check("wide_sample_cnt", 64'(sample_cnt), 64'd43);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
